rx_host_fifo: RTL and testbench

Receive-side host buffer sitting directly downstream of the UART receive controller and its shift register. Captures each completed byte on the controller's load pulse into a small first-word-fall-through FIFO and presents it to the host over a valid/ready handshake. Drives notReady back to the controller when full. Counts overrun (halt) and framing-error (error) events for host status reads.

---
 rtl/rx_host_fifo.sv | 95 +++++++++
 tb/tb_rx_host_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rx_host_fifo.sv
// Receive-side host buffer: captures controller load pulses into a FWFT FIFO and
// presents bytes to the host over valid/ready, with saturating overrun/framing counters.
module rx_host_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  sampleClk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rxData,
    input  logic                  load,
    input  logic                  halt,
    input  logic                  error,
    output logic                  notReady,
    output logic [DATA_WIDTH-1:0] hostData,
    output logic                  hostValid,
    input  logic                  hostReady,
    output logic [PTR_WIDTH:0]    level,
    output logic [CNT_WIDTH-1:0]  overrunCount,
    output logic [CNT_WIDTH-1:0]  frameErrCount,
    input  logic                  clrCounts
);

    localparam logic [PTR_WIDTH:0] FULL_LVL = (PTR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0]   level_q, level_d;
    logic [CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;
    logic [CNT_WIDTH-1:0] fe_cnt_q, fe_cnt_d;

    logic full, empty, push, pop, ovr_evt;

    always_comb begin
        full      = (level_q == FULL_LVL);
        empty     = (level_q == '0);
        push      = load & ~full;
        pop       = ~empty & hostReady;
        // A load that arrives while full is dropped and counted like a halt.
        ovr_evt   = halt | (load & full);

        wr_ptr_d  = wr_ptr_q + PTR_WIDTH'(push);
        rd_ptr_d  = rd_ptr_q + PTR_WIDTH'(pop);

        level_d   = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        ovr_cnt_d = ovr_cnt_q;
        fe_cnt_d  = fe_cnt_q;
        if (clrCounts) begin
            ovr_cnt_d = '0;
            fe_cnt_d  = '0;
        end else begin
            if (ovr_evt && (ovr_cnt_q != '1)) ovr_cnt_d = ovr_cnt_q + 1'b1;
            if (error && (fe_cnt_q != '1))    fe_cnt_d  = fe_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge sampleClk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovr_cnt_q <= '0;
            fe_cnt_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovr_cnt_q <= ovr_cnt_d;
            fe_cnt_q  <= fe_cnt_d;
        end
    end

    always_ff @(posedge sampleClk) begin
        if (push) mem_q[wr_ptr_q] <= rxData;
    end

    always_comb begin
        hostValid     = ~empty;
        notReady      = full;
        hostData      = hostValid ? mem_q[rd_ptr_q] : '0;
        level         = level_q;
        overrunCount  = ovr_cnt_q;
        frameErrCount = fe_cnt_q;
    end

endmodule

// File: tb/tb_rx_host_fifo.sv
// Scoreboard bench for rx_host_fifo: queue model of FIFO contents plus counter models.
module tb_rx_host_fifo;

    localparam int DW = 8;
    localparam int DEPTH = 4;

    logic          sampleClk = 1'b0;
    logic          rst;
    logic [DW-1:0] rxData;
    logic          load, halt, error, hostReady, clrCounts;
    logic          notReady, hostValid;
    logic [DW-1:0] hostData;
    logic [2:0]    level;
    logic [7:0]    overrunCount, frameErrCount;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb_q[$];
    int exp_ovr = 0;
    int exp_fe  = 0;

    rx_host_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_WIDTH(2), .CNT_WIDTH(8)) dut (
        .sampleClk     (sampleClk),
        .rst           (rst),
        .rxData        (rxData),
        .load          (load),
        .halt          (halt),
        .error         (error),
        .notReady      (notReady),
        .hostData      (hostData),
        .hostValid     (hostValid),
        .hostReady     (hostReady),
        .level         (level),
        .overrunCount  (overrunCount),
        .frameErrCount (frameErrCount),
        .clrCounts     (clrCounts)
    );

    always #5 sampleClk = ~sampleClk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Sampled mid-cycle: a handshake seen here completes at the next rising edge.
    always @(negedge sampleClk) begin
        if (!rst) begin
            chk("hostValid", {31'd0, hostValid}, {31'd0, sb_q.size() != 0});
            chk("level", {29'd0, level}, sb_q.size());
            chk("notReady", {31'd0, notReady}, {31'd0, sb_q.size() == DEPTH});
            if (sb_q.size() == 0)
                chk("hostData_idle", {24'd0, hostData}, 32'd0);
            else if (hostReady)
                chk("pop_data", {24'd0, hostData}, {24'd0, sb_q.pop_front()});
        end
    end

    // Drives one cycle of inputs, then advances the model across the next edge.
    task automatic step(input logic ld, input logic [DW-1:0] dat, input logic hr,
                        input logic hl, input logic er, input logic clr);
        bit was_full;
        load = ld; rxData = dat; hostReady = hr; halt = hl; error = er; clrCounts = clr;
        was_full = (sb_q.size() == DEPTH);
        @(posedge sampleClk);
        #1;
        if (ld && !was_full) sb_q.push_back(dat);
        if (clr) begin
            exp_ovr = 0;
            exp_fe  = 0;
        end else begin
            if ((hl || (ld && was_full)) && exp_ovr < 255) exp_ovr++;
            if (er && exp_fe < 255) exp_fe++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_ovr"}, {24'd0, overrunCount}, exp_ovr);
        chk({tag, "_fe"}, {24'd0, frameErrCount}, exp_fe);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        load = 0; halt = 0; error = 0; hostReady = 0; clrCounts = 0; rxData = '0;
        #12;
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_hostValid", {31'd0, hostValid}, 32'd0);
        chk("rst_hostData", {24'd0, hostData}, 32'd0);
        chk("rst_notReady", {31'd0, notReady}, 32'd0);
        chk_cnts("rst");
        @(negedge sampleClk);
        rst = 1'b0;
        @(posedge sampleClk);
        #1;
        idle(2);

        // single write then one pop
        step(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("single_valid", {31'd0, hostValid}, 32'd1);
        chk("single_data", {24'd0, hostData}, 32'hA5);
        chk("single_level", {29'd0, level}, 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("single_drained", {31'd0, hostValid}, 32'd0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("ready_when_empty", {29'd0, level}, 32'd0);

        // fill, overflow, drain, wrap
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i * 8'h11), 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_level", {29'd0, level}, 32'd4);
        chk("full_notReady", {31'd0, notReady}, 32'd1);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnts("load_full");
        step(1'b1, 8'h56, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_cnts("load_halt_full");
        chk("full_data_kept", {24'd0, hostData}, 32'h11);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("drained_level", {29'd0, level}, 32'd0);
        step(1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wrap_head", {24'd0, hostData}, 32'hB1);
        idle(1);

        // simultaneous push and pop at level 2
        step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pushpop_level", {29'd0, level}, 32'd2);
        chk("pushpop_head", {24'd0, hostData}, 32'hB2);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("pushpop_new", {24'd0, hostData}, 32'h66);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);

        // event counters
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_cnts("err3");
        for (int i = 0; i < 300; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovr_sat", {24'd0, overrunCount}, 32'hFF);
        chk_cnts("halt300");
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_cnts("clr_wins");

        // async reset between edges with data in flight
        step(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("pre_rst_level", {29'd0, level}, 32'd3);
        #2;
        rst = 1'b1;
        sb_q.delete();
        exp_ovr = 0;
        exp_fe = 0;
        #1;
        chk("arst_hostValid", {31'd0, hostValid}, 32'd0);
        chk("arst_notReady", {31'd0, notReady}, 32'd0);
        chk("arst_level", {29'd0, level}, 32'd0);
        chk("arst_hostData", {24'd0, hostData}, 32'd0);
        chk_cnts("arst");
        @(negedge sampleClk);
        #1;
        rst = 1'b0;
        @(posedge sampleClk);
        #1;
        step(1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_data", {24'd0, hostData}, 32'h7E);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        chk("end_empty", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
